// File: rtl/sample_fetch_dp_if.sv
// Bundle of the controller handshake, configuration and both SRAM ports seen by
// the sample fetch datapath. The datapath uses the slave view; the environment
// (controller plus SRAMs) uses the master view.
interface sample_fetch_dp_if #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned FRAMEADDR  = 16,
  parameter int unsigned SAMPLEADDR = 16
);
  // Controller handshake
  logic                  enable;
  logic                  load;
  logic                  store;        // active low
  logic                  done;
  logic                  got_it;
  logic                  sram_full;
  // Configuration
  logic [7:0]            cfg_stride;
  logic [DATAWIDTH-1:0]  cfg_thresh;
  // Frame SRAM read port
  logic                  frame_cs;
  logic [FRAMEADDR-1:0]  frame_addr;
  logic [DATAWIDTH-1:0]  frame_rdata;
  // Sample SRAM write port
  logic                  sample_we_n;
  logic [SAMPLEADDR-1:0] sample_addr;
  logic [DATAWIDTH-1:0]  sample_wdata;
  // Status
  logic [SAMPLEADDR:0]   sample_count;
  logic                  frame_wrap;

  modport master (
    output enable, load, store, done, cfg_stride, cfg_thresh, frame_rdata,
    input  got_it, sram_full, frame_cs, frame_addr, sample_we_n, sample_addr,
           sample_wdata, sample_count, frame_wrap
  );

  modport slave (
    input  enable, load, store, done, cfg_stride, cfg_thresh, frame_rdata,
    output got_it, sram_full, frame_cs, frame_addr, sample_we_n, sample_addr,
           sample_wdata, sample_count, frame_wrap
  );
endinterface

// File: rtl/sample_fetch_dp.sv
// Sample fetch datapath: walks the frame SRAM on controller load strobes, keeps
// every Nth pixel at or above a threshold, and writes kept pixels into the
// sample SRAM on controller store strobes until the sample SRAM is full.
module sample_fetch_dp #(
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned FRAMEADDR    = 16,
  parameter int unsigned SAMPLEADDR   = 16,
  parameter int unsigned FRAME_DEPTH  = 65536,
  parameter int unsigned SAMPLE_DEPTH = 65536
) (
  input logic               clk,
  input logic               rst,
  sample_fetch_dp_if.slave  bus
);

  localparam logic [FRAMEADDR-1:0]  FrameLast  = FRAMEADDR'(FRAME_DEPTH - 1);
  localparam logic [SAMPLEADDR-1:0] SampleLast = SAMPLEADDR'(SAMPLE_DEPTH - 1);
  localparam logic [SAMPLEADDR:0]   SampleFull = (SAMPLEADDR + 1)'(SAMPLE_DEPTH);

  typedef enum logic [1:0] {StIdle, StActive, StFull} state_e;

  state_e                state_q, state_d;
  logic [FRAMEADDR-1:0]  frame_addr_q, frame_addr_d;
  logic [SAMPLEADDR-1:0] sample_addr_q, sample_addr_d;
  logic [SAMPLEADDR:0]   sample_count_q, sample_count_d;
  logic [7:0]            stride_cnt_q, stride_cnt_d;
  logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
  logic                  frame_wrap_q, frame_wrap_d;

  logic                  active;
  logic                  keep;
  logic [7:0]            stride_last;

  // Outputs are forced to their reset values while rst is high so nothing is
  // written in the reset cycle.
  assign active      = (state_q == StActive) && !rst;
  assign keep        = (stride_cnt_q == 8'd0) && (bus.frame_rdata >= bus.cfg_thresh);
  assign stride_last = (bus.cfg_stride == 8'd0) ? 8'd0 : bus.cfg_stride - 8'd1;

  assign bus.frame_cs     = active;
  assign bus.got_it       = bus.load & active & keep;
  assign bus.sample_we_n  = bus.store | ~active;
  assign bus.sram_full    = !rst && ((state_q == StFull) ||
                                     ((state_q == StActive) && (sample_addr_q == SampleLast)));
  assign bus.frame_addr   = frame_addr_q;
  assign bus.sample_addr  = sample_addr_q;
  assign bus.sample_wdata = wdata_q;
  assign bus.sample_count = sample_count_q;
  assign bus.frame_wrap   = frame_wrap_q;

  // Next-state and counter updates.
  always_comb begin
    state_d        = state_q;
    frame_addr_d   = frame_addr_q;
    sample_addr_d  = sample_addr_q;
    sample_count_d = sample_count_q;
    stride_cnt_d   = stride_cnt_q;
    wdata_d        = wdata_q;
    frame_wrap_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d        = StActive;
          frame_addr_d   = '0;
          sample_addr_d  = '0;
          sample_count_d = '0;
          stride_cnt_d   = '0;
        end
      end
      StActive: begin
        if (bus.load) begin
          if (frame_addr_q == FrameLast) begin
            frame_addr_d = '0;
            frame_wrap_d = 1'b1;
          end else begin
            frame_addr_d = frame_addr_q + 1'b1;
          end
          // >= keeps the counter bounded if cfg_stride shrinks mid-run.
          stride_cnt_d = (stride_cnt_q >= stride_last) ? 8'd0 : stride_cnt_q + 8'd1;
          if (keep) wdata_d = bus.frame_rdata;
        end
        if (!bus.store) begin
          if (sample_addr_q == SampleLast) begin
            state_d        = StFull;
            sample_count_d = SampleFull;
          end else begin
            sample_addr_d  = sample_addr_q + 1'b1;
            sample_count_d = sample_count_q + 1'b1;
          end
        end
        if (bus.done) state_d = StIdle;
      end
      StFull: begin
        if (bus.done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      frame_addr_q   <= '0;
      sample_addr_q  <= '0;
      sample_count_q <= '0;
      stride_cnt_q   <= '0;
      wdata_q        <= '0;
      frame_wrap_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_addr_q   <= frame_addr_d;
      sample_addr_q  <= sample_addr_d;
      sample_count_q <= sample_count_d;
      stride_cnt_q   <= stride_cnt_d;
      wdata_q        <= wdata_d;
      frame_wrap_q   <= frame_wrap_d;
    end
  end

endmodule

// File: tb/tb_sample_fetch_dp.sv
// Self-checking bench for sample_fetch_dp with an 8-pixel frame and a 4-slot
// sample SRAM. Expected sample writes go into a queue when a store is driven
// and are checked by a monitor whenever the DUT writes.
module tb_sample_fetch_dp;

  localparam int FD = 8;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_fetch_dp_if #(.DATAWIDTH(32), .FRAMEADDR(16), .SAMPLEADDR(16)) bus ();

  sample_fetch_dp #(
    .DATAWIDTH(32), .FRAMEADDR(16), .SAMPLEADDR(16),
    .FRAME_DEPTH(FD), .SAMPLE_DEPTH(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Frame SRAM model: registered read, one cycle latency.
  logic [31:0] mem [0:FD-1];
  always @(posedge clk) begin
    if (bus.frame_cs) bus.frame_rdata <= mem[bus.frame_addr[2:0]];
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 active, 2 full.
  int          m_st, m_faddr, m_stride, m_saddr, m_cnt;
  logic [31:0] m_wdata;
  int          got_cnt, wrap_cnt;

  // Write monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.sample_we_n === 1'b0) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h, no write expected",
                 bus.sample_addr, bus.sample_wdata);
      end else begin
        e = exp_q.pop_front();
        if (int'(bus.sample_addr) !== e.addr || bus.sample_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.sample_addr, bus.sample_wdata, e.addr, e.data);
        end
      end
    end
    if (bus.got_it === 1'b1) got_cnt++;
    if (bus.frame_wrap === 1'b1) wrap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_st = 0; m_faddr = 0; m_stride = 0; m_saddr = 0; m_cnt = 0; m_wdata = '0;
  endtask

  task automatic do_start();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    m_st = 1; m_faddr = 0; m_stride = 0; m_saddr = 0; m_cnt = 0;
    tick();
  endtask

  task automatic do_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    m_st = 0;
  endtask

  task automatic do_load();
    logic exp_got, exp_wrap;
    int   last;
    last    = (bus.cfg_stride == 0) ? 0 : int'(bus.cfg_stride) - 1;
    exp_got = (m_st == 1) && (m_stride == 0) && (mem[m_faddr] >= bus.cfg_thresh);
    bus.load = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.got_it !== exp_got) begin
      errors++;
      $display("FAIL got_it load@%0d: got %b expected %b", m_faddr, bus.got_it, exp_got);
    end
    tick();
    bus.load = 1'b0;
    exp_wrap = 1'b0;
    if (m_st == 1) begin
      if (exp_got) m_wdata = mem[m_faddr];
      exp_wrap = (m_faddr == FD - 1);
      m_faddr  = (m_faddr == FD - 1) ? 0 : m_faddr + 1;
      m_stride = (m_stride >= last) ? 0 : m_stride + 1;
    end
    @(negedge clk);
    checks++;
    if (bus.frame_wrap !== exp_wrap || int'(bus.frame_addr) !== m_faddr) begin
      errors++;
      $display("FAIL after_load wrap=%b addr=%0d expected wrap=%b addr=%0d",
               bus.frame_wrap, bus.frame_addr, exp_wrap, m_faddr);
    end
    tick();
    checks++;
    if (bus.frame_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse width: got %b expected 0", bus.frame_wrap);
    end
  endtask

  task automatic do_store();
    logic exp_full;
    exp_full = (m_st == 2) || (m_st == 1 && m_saddr == SD - 1);
    if (m_st == 1) exp_q.push_back('{addr: m_saddr, data: m_wdata});
    bus.store = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sram_full !== exp_full) begin
      errors++;
      $display("FAIL sram_full in store: got %b expected %b", bus.sram_full, exp_full);
    end
    tick();
    bus.store = 1'b1;
    if (m_st == 1) begin
      if (m_saddr == SD - 1) begin
        m_st = 2; m_cnt = SD;
      end else begin
        m_saddr++; m_cnt++;
      end
    end
    @(negedge clk);
    checks++;
    if (int'(bus.sample_count) !== m_cnt || int'(bus.sample_addr) !== m_saddr) begin
      errors++;
      $display("FAIL after_store count=%0d addr=%0d expected count=%0d addr=%0d",
               bus.sample_count, bus.sample_addr, m_cnt, m_saddr);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 12; i++) begin
      bus.load  = 1'($urandom_range(0, 1));
      bus.store = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.got_it !== 1'b0 || bus.sample_we_n !== 1'b1 || bus.frame_cs !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs got_it=%b we_n=%b cs=%b expected 0 1 0",
                 bus.got_it, bus.sample_we_n, bus.frame_cs);
      end
      tick();
    end
    bus.load = 1'b0; bus.store = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.frame_addr !== 16'd0 || bus.sample_addr !== 16'd0 || bus.sample_count !== 17'd0 ||
        bus.frame_wrap !== 1'b0 || bus.sram_full !== 1'b0) begin
      errors++;
      $display("FAIL idle_counters faddr=%0d saddr=%0d cnt=%0d wrap=%b full=%b expected all 0",
               bus.frame_addr, bus.sample_addr, bus.sample_count, bus.frame_wrap, bus.sram_full);
    end
    tick();
  endtask

  task automatic test_basic_keep();
    bus.cfg_stride = 8'd1; bus.cfg_thresh = 32'd0;
    mem[0] = 32'hA5;
    do_start();
    do_load();
    checks++;
    if (bus.sample_wdata !== 32'hA5) begin
      errors++;
      $display("FAIL basic_wdata got %h expected a5", bus.sample_wdata);
    end
    do_store();
    do_done();
  endtask

  task automatic test_thresh_stride();
    logic [31:0] pix [0:6];
    pix = '{32'h20, 32'h30, 32'h40, 32'h05, 32'h50, 32'h60, 32'h70};
    for (int i = 0; i < 7; i++) mem[i] = pix[i];
    bus.cfg_stride = 8'd3; bus.cfg_thresh = 32'h10;
    do_start();
    got_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      do_load();
      if (i == 0 || i == 6) do_store();
    end
    checks++;
    if (got_cnt !== 2) begin
      errors++;
      $display("FAIL thresh_stride keeps got %0d expected 2", got_cnt);
    end
    do_done();
  endtask

  task automatic test_fill();
    for (int i = 0; i < FD; i++) mem[i] = 32'h100 + i;
    bus.cfg_stride = 8'd0; bus.cfg_thresh = 32'd0;
    do_start();
    for (int i = 0; i < SD; i++) begin
      do_load();
      do_store();
    end
    checks++;
    if (bus.sram_full !== 1'b1 || bus.frame_cs !== 1'b0 || bus.sample_count !== 17'd4) begin
      errors++;
      $display("FAIL fill_state full=%b cs=%b cnt=%0d expected 1 0 4",
               bus.sram_full, bus.frame_cs, bus.sample_count);
    end
    do_load();
    do_store();
    do_done();
    @(negedge clk);
    checks++;
    if (bus.sram_full !== 1'b0 || bus.sample_count !== 17'd4) begin
      errors++;
      $display("FAIL fill_done full=%b cnt=%0d expected 0 4", bus.sram_full, bus.sample_count);
    end
    tick();
  endtask

  task automatic test_frame_wrap();
    bus.cfg_stride = 8'd1; bus.cfg_thresh = 32'd0;
    do_start();
    wrap_cnt = 0;
    for (int i = 0; i < FD + 1; i++) do_load();
    checks++;
    if (wrap_cnt !== 1 || bus.frame_addr !== 16'd1) begin
      errors++;
      $display("FAIL frame_wrap pulses=%0d addr=%0d expected 1 1", wrap_cnt, bus.frame_addr);
    end
    do_done();
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < FD; i++) mem[i] = 32'h200 + i;
    bus.cfg_stride = 8'd1; bus.cfg_thresh = 32'd0;
    do_start();
    do_load(); do_store();
    do_load(); do_store();
    bus.store = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sample_we_n !== 1'b1 || bus.frame_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle we_n=%b cs=%b expected 1 0", bus.sample_we_n, bus.frame_cs);
    end
    tick();
    rst = 1'b0;
    bus.store = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus.sample_addr !== 16'd0 || bus.sample_count !== 17'd0 || bus.frame_addr !== 16'd0 ||
        bus.sample_wdata !== 32'd0 || bus.sram_full !== 1'b0 || bus.frame_cs !== 1'b0) begin
      errors++;
      $display("FAIL after_reset saddr=%0d cnt=%0d faddr=%0d wdata=%h full=%b cs=%b",
               bus.sample_addr, bus.sample_count, bus.frame_addr, bus.sample_wdata,
               bus.sram_full, bus.frame_cs);
    end
    tick();
    do_start();
    do_load();
    do_store();
    do_done();
  endtask

  initial begin
    bus.enable = 1'b0; bus.load = 1'b0; bus.store = 1'b1; bus.done = 1'b0;
    bus.cfg_stride = 8'd1; bus.cfg_thresh = 32'd0;
    for (int i = 0; i < FD; i++) mem[i] = '0;
    model_clear();
    got_cnt = 0; wrap_cnt = 0;
    rst = 1'b1;
    tick();
    test_reset();
    test_basic_keep();
    test_thresh_stride();
    test_fill();
    test_frame_wrap();
    test_reset_midrun();
    tick();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_writes pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_fetch_dp.md
Name: sample_fetch_dp

Overview:
- Datapath companion to the sampling controller.
- Reads pixels from the frame SRAM and decides per pixel whether to keep it (stride + threshold); the decision is returned to the controller as got_it.
- On the controller's store strobe, writes the kept pixel into the sample SRAM and advances the sample address; raises sram_full on the last slot.
- Sits between the frame SRAM, the sample SRAM and the sampling controller; consumes enable/load/store/done, produces got_it/sram_full.

Parameters:
- DATAWIDTH, 32, pixel/sample word width
- FRAMEADDR, 16, frame SRAM address width
- SAMPLEADDR, 16, sample SRAM address width
- FRAME_DEPTH, 65536, pixels per frame; frame address wraps after FRAME_DEPTH-1
- SAMPLE_DEPTH, 65536, sample SRAM capacity; must be ≤ 2^SAMPLEADDR and ≥ 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  start request (same signal the controller sees)
- load  in  1  controller load strobe, one cycle
- store  in  1  controller store strobe, active low
- done  in  1  controller done pulse; returns the block to idle
- cfg_stride  in  8  keep every Nth loaded pixel; 0 treated as 1
- cfg_thresh  in  DATAWIDTH  minimum unsigned pixel value to keep
- got_it  out  1  pixel kept (combinational, valid during load)
- sram_full  out  1  current/next store fills the sample SRAM
- frame_cs  out  1  frame SRAM read enable
- frame_addr  out  FRAMEADDR  frame SRAM read address
- frame_rdata  in  DATAWIDTH  frame SRAM data; registered read, 1-cycle latency
- sample_we_n  out  1  sample SRAM write enable, active low
- sample_addr  out  SAMPLEADDR  sample SRAM write address
- sample_wdata  out  DATAWIDTH  sample SRAM write data
- sample_count  out  SAMPLEADDR+1  number of samples written since start
- frame_wrap  out  1  one-cycle registered pulse when frame_addr wraps

Behaviour:
- States: IDLE, ACTIVE, FULL.
- Reset: state=IDLE; frame_addr=0, sample_addr=0, sample_count=0, stride_cnt=0, sample_wdata reg=0, frame_wrap=0. Outputs: frame_cs=0, got_it=0, sram_full=0, sample_we_n=1.
- IDLE --enable--> ACTIVE. On that edge, clear frame_addr, sample_addr, sample_count and stride_cnt.
- Enable while in ACTIVE or FULL is ignored.
- frame_cs=1 whenever state is ACTIVE. frame_addr changes only on a load edge, so the data for the current address is valid in the cycle after the address is presented. The controller always inserts at least one cycle between loads, so frame_rdata is always valid during load.
- keep = (stride_cnt==0) && (frame_rdata >= cfg_thresh), unsigned compare.
- got_it = load & (state==ACTIVE) & keep. It is combinational in the load cycle.
- On a load edge in ACTIVE:
  - frame_addr increments; at FRAME_DEPTH-1 it wraps to 0 and frame_wrap pulses in the next cycle.
  - stride_cnt increments; it wraps to 0 at max(cfg_stride,1)-1.
  - If got_it, frame_rdata is captured into sample_wdata.
- sample_we_n = store | (state!=ACTIVE).
- On a store-low edge in ACTIVE:
  - sample_addr and sample_count increment.
  - If sample_addr==SAMPLE_DEPTH-1, go to FULL instead; sample_addr holds and sample_count becomes SAMPLE_DEPTH.
- sram_full = (state==FULL) | ((state==ACTIVE) & (sample_addr==SAMPLE_DEPTH-1)), so it is high in the STORE cycle that writes the last slot.
- In FULL:
  - frame_cs=0, got_it=0, sample_we_n=1; load and store have no effect.
  - sram_full=1 until done.
- done in ACTIVE or FULL: go to IDLE. Counters and sample_count hold until the next start.
- done in IDLE: no effect.
- Load and store-low in the same cycle cannot come from the controller. If it happens, both take effect; the store writes the old sample_wdata.
- rst mid-operation aborts immediately to reset values. No write occurs in the reset cycle.
- Load or store while IDLE: ignored; got_it=0, no counter changes.

Test Plan:
- Reset then idle: rst high 2 cycles, then drive load/store randomly without enable -> got_it=0, sample_we_n=1, all counters 0.
- Basic keep: cfg_stride=1, cfg_thresh=0, frame pixel[0]=0xA5, enable, WAIT, load -> got_it=1 in load cycle. On the next store: sample_addr=0, sample_wdata=0xA5, sample_we_n=0, then sample_count=1.
- Threshold/stride: cfg_stride=3, cfg_thresh=0x10, pixels 0x20,0x30,0x40,0x05,0x50,0x60,0x70 -> got_it on loads 0 and 6 only (load 3 fails threshold). Stored values 0x20 then 0x70.
- Fill: SAMPLE_DEPTH=4, all kept -> sram_full=1 during 4th store cycle, state FULL; a 5th store writes nothing; sample_count=4; done -> IDLE.
- Frame wrap: FRAME_DEPTH=8, 9 loads -> frame_wrap pulses once after the 8th load; frame_addr=1 after the 9th.
- Reset mid-run: assert rst in a store-low cycle with sample_addr=2 -> no write; next cycle all outputs at reset values; a fresh enable restarts at sample_addr=0.
